// File: rtl/wb_data_demux.sv
// ----------------------------------------------------------------------------
// wb_data_demux
//   1-to-4 write-back data distributor. Items {sel, data} enter over a
//   valid/ready handshake, are buffered in a small FIFO, and the head item is
//   offered to exactly one of four destinations (one-hot out_valid) sharing a
//   common out_data bus. Delivery order is strict FIFO across destinations.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   upstream item valid
//   in_ready   block can accept an item this cycle
//   in_data    item data (WIDTH bits)
//   in_sel     destination code 0..3 (0=a, 1=b, 2=c, 3=d)
//   out_valid  one-hot, bit k = head item is for destination k
//   out_ready  per-destination accept
//   out_data   head item data, shared by all destinations
//   level      current FIFO occupancy
// ----------------------------------------------------------------------------
module wb_data_demux #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [1:0]                 in_sel,
    output logic [3:0]                 out_valid,
    input  logic [3:0]                 out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
    localparam logic [PW-1:0] LAST_P  = PW'(DEPTH - 1);

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == LAST_P) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    logic [WIDTH-1:0] r_mem_data [DEPTH];
    logic [1:0]       r_mem_sel  [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_level;
    logic [3:0]       r_out_valid;
    logic [WIDTH-1:0] r_out_data;

    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic [PW-1:0]    w_rd_next;
    logic [LW-1:0]    w_level_next;
    logic [3:0]       w_valid_next;
    logic [WIDTH-1:0] w_data_next;

    // No full-bypass: readiness depends only on the registered occupancy.
    assign w_in_ready = rst_n && (r_level < DEPTH_L);
    assign w_push     = in_valid && w_in_ready;
    // out_valid is one-hot and zero when empty, so masking ignores stray readies.
    assign w_pop      = |(r_out_valid & out_ready);

    // Next occupancy, read pointer and head presentation.
    always_comb begin
        w_rd_next    = r_rd_ptr;
        w_level_next = r_level;
        w_valid_next = 4'b0000;
        w_data_next  = {WIDTH{1'b0}};

        if (w_pop) begin
            w_rd_next = ptr_inc(r_rd_ptr);
        end else begin
            w_rd_next = r_rd_ptr;
        end

        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LW'(1);
            2'b01:   w_level_next = r_level - LW'(1);
            default: w_level_next = r_level;
        endcase

        // When the FIFO is (or is about to be) drained, the slot at the new
        // read pointer is the one being written this edge, so forward the
        // incoming item to keep the one-cycle push-to-output latency.
        if (w_level_next == {LW{1'b0}}) begin
            w_valid_next = 4'b0000;
            w_data_next  = {WIDTH{1'b0}};
        end else if (w_push && (r_wr_ptr == w_rd_next)) begin
            w_valid_next = 4'b0001 << in_sel;
            w_data_next  = in_data;
        end else begin
            w_valid_next = 4'b0001 << r_mem_sel[w_rd_next];
            w_data_next  = r_mem_data[w_rd_next];
        end
    end

    // FIFO storage write on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_data[i] <= {WIDTH{1'b0}};
                r_mem_sel[i]  <= 2'b00;
            end
        end else if (w_push) begin
            r_mem_data[r_wr_ptr] <= in_data;
            r_mem_sel[r_wr_ptr]  <= in_sel;
        end
    end

    // Pointers, occupancy and registered head outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= {PW{1'b0}};
            r_rd_ptr    <= {PW{1'b0}};
            r_level     <= {LW{1'b0}};
            r_out_valid <= 4'b0000;
            r_out_data  <= {WIDTH{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            end
            r_rd_ptr    <= w_rd_next;
            r_level     <= w_level_next;
            r_out_valid <= w_valid_next;
            r_out_data  <= w_data_next;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign level     = r_level;

endmodule

// File: tb/tb_wb_data_demux.sv
module tb_wb_data_demux;

    localparam int WIDTH = 16;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [1:0]       in_sel;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       level;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model: a plain queue of {sel, data} in arrival order.
    logic [17:0] q[$];

    wb_data_demux #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Compare every output with what the queue model says.
    task automatic check_outputs();
        logic [3:0]  exp_ov;
        logic [15:0] exp_od;
        if (q.size() == 0) begin
            exp_ov = 4'b0000;
            exp_od = 16'h0000;
        end else begin
            exp_ov = 4'b0001 << q[0][17:16];
            exp_od = q[0][15:0];
        end
        chk("out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
        chk("out_data",  {16'd0, out_data},  {16'd0, exp_od});
        chk("level",     {30'd0, level},     q.size());
        chk("in_ready",  {31'd0, in_ready},  {31'd0, (q.size() < DEPTH)});
    endtask

    // One clock cycle: check, drive, then advance the model at the edge.
    task automatic step(input logic v, input logic [15:0] d, input logic [1:0] s,
                        input logic [3:0] r);
        logic exp_push;
        logic exp_pop;
        @(negedge clk);
        check_outputs();
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = r;
        exp_push  = v && (q.size() < DEPTH);
        exp_pop   = (q.size() > 0) && r[q[0][17:16]];
        @(posedge clk);
        if (exp_pop)  void'(q.pop_front());
        if (exp_push) q.push_back({s, d});
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 16'h1234;
        in_sel    = 2'd1;
        out_ready = 4'b1111;

        // Reset held with in_valid asserted.
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_out_data",  {16'd0, out_data},  32'd0);
        chk("rst_level",     {30'd0, level},     32'd0);
        in_valid = 1'b0;
        rst_n    = 1'b1;
        #1;
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);

        // Single item to destination c, popped the next cycle.
        step(1'b1, 16'hA5A5, 2'd2, 4'b0000);
        step(1'b0, 16'h0000, 2'd0, 4'b0100);
        step(1'b0, 16'h0000, 2'd0, 4'b0000);

        // Fill to full, attempt a third push, then pop destination a.
        step(1'b1, 16'h0001, 2'd0, 4'b0000);
        step(1'b1, 16'h0002, 2'd3, 4'b0000);
        step(1'b1, 16'h0003, 2'd1, 4'b0000);
        step(1'b0, 16'h0000, 2'd0, 4'b0001);
        step(1'b0, 16'h0000, 2'd0, 4'b1000);

        // Head-of-line block: head for b, every other destination ready.
        step(1'b1, 16'h0B0B, 2'd1, 4'b0000);
        step(1'b1, 16'h0C0C, 2'd0, 4'b1101);
        step(1'b0, 16'h0000, 2'd0, 4'b1101);
        step(1'b0, 16'h0000, 2'd0, 4'b0010);
        step(1'b0, 16'h0000, 2'd0, 4'b0001);

        // Streaming at level 1 with sel cycling and all destinations ready.
        step(1'b1, 16'h5000, 2'd0, 4'b1111);
        for (int i = 1; i < 12; i++) begin
            step(1'b1, 16'h5000 + 16'(i), 2'(i), 4'b1111);
        end
        step(1'b0, 16'h0000, 2'd0, 4'b1111);

        // Reset mid-stream at level 2.
        step(1'b1, 16'hDEAD, 2'd3, 4'b0000);
        step(1'b1, 16'hBEEF, 2'd2, 4'b0000);
        @(negedge clk);
        check_outputs();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("mid_rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("mid_rst_level",     {30'd0, level},     32'd0);
        chk("mid_rst_in_ready",  {31'd0, in_ready},  32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 16'h0000, 2'd0, 4'b1111);
        step(1'b0, 16'h0000, 2'd0, 4'b1111);

        // Randomized traffic against the queue model.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 3) != 0), 16'($urandom), 2'($urandom),
                 4'($urandom));
        end
        @(negedge clk);
        check_outputs();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
